// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: state encoding, default timing
// constants and the frame parity helper.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      INHIBIT   = 2'd1,
      SEND      = 2'd2,
      WAIT_IDLE = 2'd3
   } ps2_state_t;

   // Defaults assume a 100 MHz clock.
   localparam int unsigned PS2_INHIBIT_CYCLES = 10000;
   localparam int unsigned PS2_TIMEOUT_CYCLES = 1500000;
   localparam int unsigned PS2_FILTER_LEN     = 8;

   // Edge numbers within one host-to-device frame.
   localparam logic [3:0] PS2_LAST_DATA_EDGE = 4'd8;
   localparam logic [3:0] PS2_PARITY_EDGE    = 4'd9;
   localparam logic [3:0] PS2_STOP_EDGE      = 4'd10;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the output follows
// the line only after FILTER_LEN consecutive equal samples.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
)(
   input  logic clock,
   input  logic reset,
   input  logic line,
   output logic filtered
);

   localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] run_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         run_cnt  <= '0;
         filtered <= 1'b1;
      end else begin
         sync1 <= line;
         sync2 <= sync1;
         if (sync2 == filtered) begin
            run_cnt <= '0;
         end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
            filtered <= sync2;
            run_cnt  <= '0;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends one byte
// with odd parity clocked by the device, checks the ack and guards with a watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus released, tx_ready high, waiting for tx_valid
// INHIBIT   | clock held low; data pulled low in the last cycle (request)
// SEND      | device clocks out start/data/parity/stop, ack on edge 11
// WAIT_IDLE | lines released, waiting for clock and data both high
module ps2_transmitter
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
   parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       kclock,
   input  logic       kdata,
   output logic       kclock_oe,
   output logic       kdata_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int unsigned ICW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ICW-1:0] INHIBIT_LOAD = ICW'(INHIBIT_CYCLES - 1);
   localparam logic [WCW-1:0] WDOG_LOAD    = WCW'(TIMEOUT_CYCLES - 1);

   ps2_state_t     state;
   logic [7:0]     shift;
   logic           parity;
   logic [3:0]     edge_cnt;
   logic [ICW-1:0] inh_cnt;
   logic [WCW-1:0] wdog_cnt;
   logic           acked;

   logic kclock_f;
   logic kdata_f;
   logic kclock_prev;
   logic kclock_fell;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclock_filter (
      .clock    (clock),
      .reset    (reset),
      .line     (kclock),
      .filtered (kclock_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filter (
      .clock    (clock),
      .reset    (reset),
      .line     (kdata),
      .filtered (kdata_f)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) kclock_prev <= 1'b1;
      else       kclock_prev <= kclock_f;
   end

   assign kclock_fell = kclock_prev & ~kclock_f;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         kclock_oe <= 1'b0;
         kdata_oe  <= 1'b0;
         tx_ready  <= 1'b1;
         tx_done   <= 1'b0;
         tx_error  <= 1'b0;
         shift     <= '0;
         parity    <= 1'b0;
         edge_cnt  <= '0;
         inh_cnt   <= '0;
         wdog_cnt  <= '0;
         acked     <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         unique case (state)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  shift     <= tx_data;
                  parity    <= odd_parity(tx_data);
                  inh_cnt   <= INHIBIT_LOAD;
                  kclock_oe <= 1'b1;
                  // A one-cycle inhibit is also its own final cycle.
                  kdata_oe  <= (INHIBIT_CYCLES == 1);
                  tx_ready  <= 1'b0;
                  acked     <= 1'b0;
                  state     <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (inh_cnt == '0) begin
                  kclock_oe <= 1'b0;
                  kdata_oe  <= 1'b1;
                  edge_cnt  <= '0;
                  wdog_cnt  <= WDOG_LOAD;
                  state     <= SEND;
               end else begin
                  inh_cnt <= inh_cnt - 1'b1;
                  if (inh_cnt == ICW'(1)) kdata_oe <= 1'b1;
               end
            end

            SEND: begin
               if (kclock_fell) begin
                  wdog_cnt <= WDOG_LOAD;
                  edge_cnt <= edge_cnt + 1'b1;
                  if (edge_cnt < PS2_LAST_DATA_EDGE) begin
                     kdata_oe <= ~shift[edge_cnt[2:0]];
                  end else if (edge_cnt == PS2_LAST_DATA_EDGE) begin
                     kdata_oe <= ~parity;
                  end else if (edge_cnt == PS2_PARITY_EDGE) begin
                     kdata_oe <= 1'b0;
                  end else begin
                     // Eleventh falling edge: device drives data low to ack.
                     kdata_oe <= 1'b0;
                     acked    <= ~kdata_f;
                     tx_error <= kdata_f;
                     state    <= WAIT_IDLE;
                  end
               end else if (wdog_cnt == '0) begin
                  kclock_oe <= 1'b0;
                  kdata_oe  <= 1'b0;
                  tx_error  <= 1'b1;
                  tx_ready  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wdog_cnt <= wdog_cnt - 1'b1;
               end
            end

            WAIT_IDLE: begin
               kclock_oe <= 1'b0;
               kdata_oe  <= 1'b0;
               if (kclock_f && kdata_f) begin
                  tx_done  <= acked;
                  tx_ready <= 1'b1;
                  state    <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a simple open-drain PS/2 device model.
module tb_ps2_transmitter;

   localparam int HALF = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       kclock;
   logic       kdata;
   logic       kclock_oe;
   logic       kdata_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   always #5 clock = ~clock;

   assign kclock = dev_clk & ~kclock_oe;
   assign kdata  = dev_dat & ~kdata_oe;

   ps2_transmitter #(
      .INHIBIT_CYCLES (50),
      .TIMEOUT_CYCLES (200),
      .FILTER_LEN     (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .kclock    (kclock),
      .kdata     (kdata),
      .kclock_oe (kclock_oe),
      .kdata_oe  (kdata_oe),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_done   (tx_done),
      .tx_error  (tx_error)
   );

   always @(negedge clock) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_error === 1'b1) err_cnt++;
      if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic start_send(input logic [7:0] d);
      tick(1);
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   // Device side: wait for the start bit, clock nedges falling edges and
   // record the data line at the end of each low phase (edges 1..10).
   task automatic run_device(input int nedges, input bit ack,
                             output logic [9:0] seen, output bit started);
      int w;
      seen = '0;
      w = 0;
      while (!(kclock_oe === 1'b0 && kdata_oe === 1'b1) && w < 500) begin
         tick(1);
         w++;
      end
      started = (w < 500);
      tick(HALF);
      for (int e = 1; e <= nedges; e++) begin
         if (e == 11) begin
            dev_dat = ack ? 1'b0 : 1'b1;
            tick(HALF);
         end
         dev_clk = 1'b0;
         tick(HALF);
         if (e <= 10) seen[e-1] = kdata;
         dev_clk = 1'b1;
         dev_dat = 1'b1;
         tick(HALF);
      end
   endtask

   task automatic wait_ready(output bit ok);
      int w;
      w = 0;
      while (tx_ready !== 1'b1 && w < 300) begin
         tick(1);
         w++;
      end
      ok = (w < 300);
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      tick(3);
      total++; if (kclock_oe !== 1'b0) begin bad++; $display("FAIL reset_kclock_oe got=%b want=0", kclock_oe); end
      total++; if (kdata_oe !== 1'b0) begin bad++; $display("FAIL reset_kdata_oe got=%b want=0", kdata_oe); end
      total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
      total++; if (tx_done !== 1'b0 || tx_error !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", tx_done, tx_error); end
      reset = 1'b0;
      tick(20);
   endtask

   task automatic test_send_ed();
      int d0, e0, cyc;
      bit early, started, ok;
      logic last;
      logic [9:0] seen;
      d0 = done_cnt; e0 = err_cnt;
      start_send(8'hED);
      cyc = 0; early = 0; last = 1'b0;
      while (kclock_oe === 1'b1 && cyc < 1000) begin
         cyc++;
         if (cyc < 50 && kdata_oe !== 1'b0) early = 1;
         last = kdata_oe;
         tick(1);
      end
      total++; if (cyc != 50) begin bad++; $display("FAIL inhibit_len got=%0d want=50", cyc); end
      total++; if (early) begin bad++; $display("FAIL inhibit_data_early got=1 want=0"); end
      total++; if (last !== 1'b1) begin bad++; $display("FAIL inhibit_data_last got=%b want=1", last); end
      total++; if (kdata_oe !== 1'b1) begin bad++; $display("FAIL start_bit got=%b want=1", kdata_oe); end
      run_device(11, 1'b1, seen, started);
      total++; if (!started) begin bad++; $display("FAIL ed_start got=0 want=1"); end
      total++; if (seen !== 10'h3ED) begin bad++; $display("FAIL ed_bits got=%h want=3ed", seen); end
      wait_ready(ok);
      total++; if (!ok) begin bad++; $display("FAIL ed_ready got=0 want=1"); end
      tick(5);
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ed_done got=%0d want=1", done_cnt - d0); end
      total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL ed_error got=%0d want=0", err_cnt - e0); end
   endtask

   task automatic test_send_f4_ignore();
      int d0, e0;
      bit started, ok, restarted;
      logic [9:0] seen;
      d0 = done_cnt; e0 = err_cnt;
      start_send(8'hF4);
      tick(3);
      tx_data = 8'h55; tx_valid = 1'b1;
      tick(10);
      total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", tx_ready); end
      tx_valid = 1'b0;
      run_device(11, 1'b1, seen, started);
      total++; if (seen !== 10'h2F4) begin bad++; $display("FAIL f4_bits got=%h want=2f4", seen); end
      wait_ready(ok);
      restarted = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (kclock_oe !== 1'b0) restarted = 1;
      end
      total++; if (restarted || !ok) begin bad++; $display("FAIL f4_idle got=%b want=0", restarted | !ok); end
      total++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin bad++; $display("FAIL f4_pulses got=%0d/%0d want=1/0", done_cnt - d0, err_cnt - e0); end
   endtask

   task automatic test_no_ack();
      int d0, e0;
      bit started, ok;
      logic [9:0] seen;
      d0 = done_cnt; e0 = err_cnt;
      start_send(8'h00);
      run_device(10, 1'b1, seen, started);
      total++; if (seen !== 10'h300) begin bad++; $display("FAIL noack_bits got=%h want=300", seen); end
      tick(HALF);
      dev_clk = 1'b0;
      tick(60);
      total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL noack_error got=%0d want=1", err_cnt - e0); end
      total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL noack_wait got=%b want=0", tx_ready); end
      total++; if (kclock_oe !== 1'b0 || kdata_oe !== 1'b0) begin bad++; $display("FAIL noack_oe got=%b%b want=00", kclock_oe, kdata_oe); end
      dev_clk = 1'b1;
      wait_ready(ok);
      total++; if (!ok) begin bad++; $display("FAIL noack_ready got=0 want=1"); end
      tick(5);
      total++; if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin bad++; $display("FAIL noack_pulses got=%0d/%0d want=0/1", done_cnt - d0, err_cnt - e0); end
   endtask

   task automatic test_timeout();
      int d0, e0, w;
      bit started, hold_bad;
      logic [9:0] seen;
      d0 = done_cnt; e0 = err_cnt;
      start_send(8'h04);
      run_device(3, 1'b1, seen, started);
      dev_clk = 1'b0;
      w = 0;
      while (kdata_oe !== 1'b1 && w < 60) begin
         tick(1);
         w++;
      end
      total++; if (w >= 60) begin bad++; $display("FAIL to_edge4 got=timeout want=kdata_oe 1"); end
      hold_bad = 0;
      for (int n = 1; n <= 200; n++) begin
         tick(1);
         if (n == 5) dev_clk = 1'b1;
         if (n < 200 && (kdata_oe !== 1'b1 || tx_error !== 1'b0)) hold_bad = 1;
         if (n == 200) begin
            total++; if (hold_bad) begin bad++; $display("FAIL to_early got=1 want=0"); end
            total++; if (kdata_oe !== 1'b0 || kclock_oe !== 1'b0) begin bad++; $display("FAIL to_oe got=%b%b want=00", kclock_oe, kdata_oe); end
            total++; if (tx_error !== 1'b1) begin bad++; $display("FAIL to_error got=%b want=1", tx_error); end
            total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL to_ready got=%b want=1", tx_ready); end
         end
      end
      tick(5);
      total++; if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin bad++; $display("FAIL to_pulses got=%0d/%0d want=0/1", done_cnt - d0, err_cnt - e0); end
   endtask

   task automatic test_reset_mid();
      int d0, e0;
      bit started, ok;
      logic [9:0] seen;
      start_send(8'h5A);
      run_device(5, 1'b1, seen, started);
      dev_clk = 1'b0;
      tick(14);
      total++; if (kdata_oe !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b want=1", kdata_oe); end
      #2 reset = 1'b1;
      #1;
      total++; if (kclock_oe !== 1'b0 || kdata_oe !== 1'b0) begin bad++; $display("FAIL mid_oe got=%b%b want=00", kclock_oe, kdata_oe); end
      total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", tx_ready); end
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(20);
      d0 = done_cnt; e0 = err_cnt;
      start_send(8'hFF);
      run_device(11, 1'b1, seen, started);
      total++; if (seen !== 10'h3FF) begin bad++; $display("FAIL ff_bits got=%h want=3ff", seen); end
      wait_ready(ok);
      tick(5);
      total++; if (!ok || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin bad++; $display("FAIL ff_pulses got=%0d/%0d want=1/0", done_cnt - d0, err_cnt - e0); end
      total++; if (both_cnt != 0) begin bad++; $display("FAIL done_and_error got=%0d want=0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_send_f4_ignore();
      test_no_ack();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

endmodule
